// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board input port: register map,
// event counter sizing, popcount and saturating add.
package board_io_pkg;

    localparam logic [1:0] ADDR_STABLE = 2'd0;
    localparam logic [1:0] ADDR_RISE   = 2'd1;
    localparam logic [1:0] ADDR_CNT    = 2'd2;
    localparam logic [1:0] ADDR_FALL   = 2'd3;

    localparam int         EVT_CNT_W   = 8;
    localparam logic [7:0] EVT_CNT_MAX = 8'd255;

    typedef logic [EVT_CNT_W-1:0] evt_cnt_t;

    // Number of set bits in a 32-bit word (0..32 fits in 7 bits).
    function automatic logic [6:0] popcount32(input logic [31:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    // Event counter add that sticks at EVT_CNT_MAX instead of wrapping.
    function automatic evt_cnt_t sat_add(input evt_cnt_t a, input logic [6:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {2'b00, b};
        if (s > {1'b0, EVT_CNT_MAX}) begin
            return EVT_CNT_MAX;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced level
// and single-cycle rise/fall pulses aligned with the debounced update.
// Macro INPUT_PORT_FALLING_EDGE_EN adds the fall pulse output.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw_i,
    output logic stable_o,
`ifdef INPUT_PORT_FALLING_EDGE_EN
    output logic fall_o,
`endif
    output logic rise_o
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synced input disagrees with the debounced
    // level; adopt the new level once the disagreement lasted long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses are combinational so the parent's event flops update on the
    // same edge as stable_q.
    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
`ifdef INPUT_PORT_FALLING_EDGE_EN
    assign fall_o   = ~stable_d & stable_q;
`endif

endmodule

// File: rtl/board_input_port.sv
// Board switch input port: per-bit debouncers plus CPU-readable debounced
// state, sticky clear-on-read edge events, saturating event counter and irq.
// Macro INPUT_PORT_FALLING_EDGE_EN enables falling-edge events at addr 3.
module board_input_port
    import board_io_pkg::*;
#(
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            rd_en,
    input  logic [1:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    output logic            irq
);

    logic [N_SW-1:0] stable_w;
    logic [N_SW-1:0] rise_new;
    logic [N_SW-1:0] rise_evt_q, rise_evt_d;
`ifdef INPUT_PORT_FALLING_EDGE_EN
    logic [N_SW-1:0] fall_new;
    logic [N_SW-1:0] fall_evt_q, fall_evt_d;
    logic [31:0]     fall_evt_32, fall_new_32;
`endif
    evt_cnt_t        evt_cnt_q, evt_cnt_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q;
    logic            irq_q, irq_d;
    logic [31:0]     stable_32, rise_evt_32, rise_new_32;
    logic [6:0]      inc;
    logic            clr_rise, clr_cnt;

    for (genvar g = 0; g < N_SW; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw_i (sw_raw[g]),
            .stable_o (stable_w[g]),
`ifdef INPUT_PORT_FALLING_EDGE_EN
            .fall_o   (fall_new[g]),
`endif
            .rise_o   (rise_new[g])
        );
    end

    // Event bookkeeping and read mux. A clear only removes bits that were
    // already registered; edges landing in the same cycle survive it.
    always_comb begin
        stable_32   = '0;
        rise_evt_32 = '0;
        rise_new_32 = '0;
        stable_32[N_SW-1:0]   = stable_w;
        rise_evt_32[N_SW-1:0] = rise_evt_q;
        rise_new_32[N_SW-1:0] = rise_new;

        clr_rise = rd_en && (rd_addr == ADDR_RISE);
        clr_cnt  = rd_en && (rd_addr == ADDR_CNT);

        inc        = popcount32(rise_new_32);
        rise_evt_d = (clr_rise ? '0 : rise_evt_q) | rise_new;
        irq_d      = |rise_evt_d;
`ifdef INPUT_PORT_FALLING_EDGE_EN
        fall_evt_32 = '0;
        fall_new_32 = '0;
        fall_evt_32[N_SW-1:0] = fall_evt_q;
        fall_new_32[N_SW-1:0] = fall_new;
        inc        = inc + popcount32(fall_new_32);
        fall_evt_d = ((rd_en && (rd_addr == ADDR_FALL)) ? '0 : fall_evt_q) | fall_new;
        irq_d      = irq_d | (|fall_evt_d);
`endif

        evt_cnt_d = clr_cnt ? evt_cnt_t'(inc) : sat_add(evt_cnt_q, inc);

        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (rd_addr)
                ADDR_STABLE: rd_data_d = stable_32;
                ADDR_RISE:   rd_data_d = rise_evt_32;
                ADDR_CNT:    rd_data_d = {24'b0, evt_cnt_q};
`ifdef INPUT_PORT_FALLING_EDGE_EN
                ADDR_FALL:   rd_data_d = fall_evt_32;
`else
                ADDR_FALL:   rd_data_d = '0;
`endif
                default:     rd_data_d = '0;
            endcase
        end
    end

    // Event, counter, read-response and irq registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_evt_q <= '0;
`ifdef INPUT_PORT_FALLING_EDGE_EN
            fall_evt_q <= '0;
`endif
            evt_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rise_evt_q <= rise_evt_d;
`ifdef INPUT_PORT_FALLING_EDGE_EN
            fall_evt_q <= fall_evt_d;
`endif
            evt_cnt_q  <= evt_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            irq_q      <= irq_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_board_input_port.sv
// Directed + randomized bench for board_input_port (N_SW=16, DEBOUNCE_CYCLES=4)
// against an event-level reference model.
module tb_board_input_port;

`ifdef INPUT_PORT_FALLING_EDGE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sw_raw;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    board_input_port #(.N_SW(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (sw_raw),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: debounced level, sticky events, counter, last read.
    logic [15:0] m_stable, m_rise, m_fall;
    int          m_cnt;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_apply(input logic [15:0] v);
        logic [15:0] r, f;
        int inc;
        r = v & ~m_stable;
        f = ~v & m_stable;
        m_rise = m_rise | r;
        inc = $countones(r);
        if (FALL_EN) begin
            m_fall = m_fall | f;
            inc = inc + $countones(f);
        end
        m_cnt = (m_cnt + inc > 255) ? 255 : m_cnt + inc;
        m_stable = v;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {16'b0, m_stable};
            2'd1:    return {16'b0, m_rise};
            2'd2:    return 32'(m_cnt);
            default: return FALL_EN ? {16'b0, m_fall} : 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return (|m_rise) || (FALL_EN && (|m_fall));
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new pattern and keep it long enough to debounce fully.
    task automatic settle(input logic [15:0] v);
        sw_raw = v;
        hold(10);
        m_apply(v);
    endtask

    // Called at a negedge; issues one read and checks it in the next cycle.
    task automatic do_read(input string tag, input logic [1:0] a);
        logic [31:0] exp;
        exp = m_read(a);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check({tag, "_data"}, rd_data, exp);
        if (a == 2'd1) m_rise = '0;
        if (a == 2'd2) m_cnt = 0;
        if (a == 2'd3) m_fall = '0;
        last_rd = exp;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_valid"}, {31'b0, rd_valid}, 32'd0);
        check({tag, "_idle_hold"}, rd_data, last_rd);
    endtask

    task automatic check_irq(input string tag);
        check(tag, {31'b0, irq}, {31'b0, m_irq()});
    endtask

    initial begin
        reset_n  = 1'b0;
        sw_raw   = 16'hFFFF;
        rd_en    = 1'b0;
        rd_addr  = 2'd0;
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_cnt    = 0;
        last_rd  = '0;

        // Reset state
        hold(3);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Release: 2 sync cycles + 4 debounce cycles before stable moves
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("rel_irq_early", {31'b0, irq}, 32'd0);
        @(posedge clk);
        #1 check("rel_irq_set", {31'b0, irq}, 32'd1);
        @(negedge clk);
        m_apply(16'hFFFF);
        do_read("rel_stable", 2'd0);
        do_read("rel_rise", 2'd1);
        do_read("rel_rise2", 2'd1);
        do_read("rel_cnt", 2'd2);
        check_idle("rel");
        check_irq("rel_irq_clr");

        // All switches fall
        settle(16'h0000);
        check_irq("fall_irq");
        do_read("fall_f", 2'd3);
        do_read("fall_cnt", 2'd2);
        do_read("fall_r", 2'd1);
        check_irq("fall_irq_clr");

        // Glitch of 3 cycles on bit 3
        sw_raw = 16'h0008;
        hold(3);
        sw_raw = 16'h0000;
        hold(10);
        check_irq("glitch_irq");
        do_read("glitch_stable", 2'd0);
        do_read("glitch_rise", 2'd1);
        do_read("glitch_cnt", 2'd2);

        // Edge + read
        settle(16'h0008);
        check_irq("edge_irq");
        do_read("edge_rise", 2'd1);
        check_irq("edge_irq_clr");
        do_read("edge_rise2", 2'd1);
        do_read("edge_cnt", 2'd2);
        do_read("edge_cnt2", 2'd2);

        // Bit 5 edge registered on the same edge as the addr1 clear
        settle(16'h0088);
        sw_raw = 16'h00A8;
        hold(5);
        do_read("sim_old", 2'd1);
        m_apply(16'h00A8);
        check_irq("sim_irq");
        do_read("sim_new", 2'd1);
        do_read("sim_cnt", 2'd2);
        check_idle("sim");

        // Saturation: 300 rising edges on bit 0 without reading the counter
        for (int i = 0; i < 300; i++) begin
            settle(16'h00A9);
            settle(16'h00A8);
        end
        do_read("sat_cnt", 2'd2);
        do_read("sat_cnt2", 2'd2);
        do_read("sat_rise", 2'd1);
        do_read("sat_fall", 2'd3);

        // Falling-edge feature on bit 0
        settle(16'h00A9);
        do_read("feat_pre_r", 2'd1);
        do_read("feat_pre_c", 2'd2);
        do_read("feat_pre_f", 2'd3);
        check_irq("feat_irq_pre");
        settle(16'h00A8);
        check_irq("feat_irq");
        do_read("feat_fall", 2'd3);
        check_irq("feat_irq_clr");

        // Randomized patterns with short glitches and random reads
        for (int i = 0; i < 30; i++) begin
            logic [15:0] pat;
            pat = 16'($urandom);
            settle(pat);
            if ($urandom_range(0, 1) == 1) begin
                sw_raw = pat ^ 16'($urandom);
                hold($urandom_range(1, 3));
                sw_raw = pat;
                hold(10);
            end
            check_irq($sformatf("rnd%0d_irq", i));
            do_read($sformatf("rnd%0d_rd", i), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) check_idle($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
